// File: rtl/phi_gate_gen_pkg.sv
// Shared types, default timing constants and helpers for the phi0/phi2 gate generator.
package phi_gate_gen_pkg;

    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        ACQUIRE  = 2'd1,
        LOCKED   = 2'd2
    } phi_state_e;

    localparam int LEN_W        = 8;
    localparam int DEF_GATE_ON  = 3;
    localparam int DEF_GATE_OFF = 2;
    localparam int DEF_TOL      = 1;
    localparam int DEF_TIMEOUT  = 200;

    function automatic logic [LEN_W-1:0] absdiff(input logic [LEN_W-1:0] a,
                                                 input logic [LEN_W-1:0] b);
        return (a > b) ? (a - b) : (b - a);
    endfunction

endpackage

// File: rtl/phi_gate_gen_if.sv
// Pin-side bundle of the gate generator: TED inputs, 6502/latch outputs and status.
interface phi_gate_gen_if
    import phi_gate_gen_pkg::*;
#(
    parameter int CW = LEN_W
);
    logic          phi0_in;
    logic          aec_in;
    logic          phi2_out;
    logic          gate_out;
    logic          aec_out;
    logic          cycle_start;
    logic [CW-1:0] high_len;
    logic          locked;
    logic          timing_err;
    phi_state_e    state;

    modport master (
        input  phi0_in, aec_in,
        output phi2_out, gate_out, aec_out, cycle_start, high_len, locked, timing_err, state
    );

    modport slave (
        output phi0_in, aec_in,
        input  phi2_out, gate_out, aec_out, cycle_start, high_len, locked, timing_err, state
    );
endinterface

// File: rtl/phi_gate_gen_sync2.sv
// Two-flop synchronizer with asynchronous active-low reset to 0.
module sync2 #(
    parameter int W = 1
) (
    input  logic         clock,
    input  logic         _reset,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    logic [W-1:0] meta;

    always_ff @(posedge clock or negedge _reset) begin
        if (!_reset) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/phi_gate_gen.sv
// Samples TED phi0/AEC, measures the phi0 high phase, tracks lock and opens the
// R/W latch gate inside a window that closes a fixed margin before the predicted fall.
module phi_gate_gen
    import phi_gate_gen_pkg::*;
#(
    parameter int CW       = LEN_W,
    parameter int GATE_ON  = DEF_GATE_ON,
    parameter int GATE_OFF = DEF_GATE_OFF,
    parameter int TOL      = DEF_TOL,
    parameter int TIMEOUT  = DEF_TIMEOUT
) (
    input  logic           clock,
    input  logic           _reset,
    phi_gate_gen_if.master bus
);
    localparam logic [CW-1:0] TMO     = CW'(TIMEOUT);
    localparam logic [CW:0]   ON_PT   = (CW+1)'(GATE_ON - 1);
    localparam logic [CW:0]   MIN_LEN = (CW+1)'(GATE_ON + GATE_OFF + 1);

    logic          phi0_s, phi0_d;
    logic          rise, fall, edge_seen, timeout;
    logic [CW-1:0] hcnt, hcnt_nxt, new_len, idle_cnt, idle_nxt;
    logic [CW-1:0] high_len_q, ref_len, ref_nxt;
    logic [CW:0]   hcnt_inc, off_pt, hn_ext;
    logic          short_len, in_win, gate_nxt;
    logic          gate_q, cstart_q, locked_q, err_q;
    phi_state_e    state_q, state_nxt;

    sync2 #(.W(1)) u_sync_phi0 (.clock(clock), ._reset(_reset), .d(bus.phi0_in), .q(phi0_s));
    sync2 #(.W(1)) u_sync_aec  (.clock(clock), ._reset(_reset), .d(bus.aec_in),  .q(bus.aec_out));

    assign rise      = phi0_s & ~phi0_d;
    assign fall      = ~phi0_s & phi0_d;
    assign edge_seen = rise | fall;
    assign timeout   = ~edge_seen & (idle_cnt == TMO);

    // new_len doubles as the saturated hcnt increment and the length captured on a fall
    assign hcnt_inc = {1'b0, hcnt} + (CW+1)'(1);
    assign new_len  = hcnt_inc[CW] ? '1 : hcnt_inc[CW-1:0];

    always_comb begin
        hcnt_nxt = hcnt;
        idle_nxt = idle_cnt;
        if (rise)        hcnt_nxt = '0;
        else if (phi0_s) hcnt_nxt = new_len;
        if (edge_seen)           idle_nxt = CW'(1);
        else if (idle_cnt != TMO) idle_nxt = idle_cnt + CW'(1);
    end

    always_comb begin
        state_nxt = state_q;
        ref_nxt   = ref_len;
        if (timeout) begin
            state_nxt = UNLOCKED;
        end else if (fall) begin
            case (state_q)
                UNLOCKED: begin
                    state_nxt = ACQUIRE;
                    ref_nxt   = new_len;
                end
                ACQUIRE: begin
                    if (absdiff(LEN_W'(new_len), LEN_W'(ref_len)) <= LEN_W'(TOL)) state_nxt = LOCKED;
                    else                                                        ref_nxt   = new_len;
                end
                LOCKED: begin
                    if (absdiff(LEN_W'(new_len), LEN_W'(high_len_q)) > LEN_W'(TOL)) begin
                        state_nxt = ACQUIRE;
                        ref_nxt   = new_len;
                    end
                end
                default: state_nxt = UNLOCKED;
            endcase
        end
    end

    // Gate is registered from next-cycle hcnt, so it is high exactly while hcnt
    // sits in [GATE_ON-1, high_len-GATE_OFF-1]; any fall or lock loss clears it next clock.
    always_comb begin
        hn_ext    = {1'b0, hcnt_nxt};
        off_pt    = {1'b0, high_len_q} - (CW+1)'(GATE_OFF + 1);
        short_len = ({1'b0, high_len_q} < MIN_LEN);
        in_win    = (hn_ext >= ON_PT) && (hn_ext <= off_pt);
        gate_nxt  = (state_nxt == LOCKED) && phi0_s && !short_len && in_win;
    end

    always_ff @(posedge clock or negedge _reset) begin
        if (!_reset) begin
            phi0_d     <= 1'b0;
            hcnt       <= '0;
            idle_cnt   <= '0;
            high_len_q <= '0;
            ref_len    <= '0;
            state_q    <= UNLOCKED;
            locked_q   <= 1'b0;
            gate_q     <= 1'b0;
            cstart_q   <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            phi0_d   <= phi0_s;
            hcnt     <= hcnt_nxt;
            idle_cnt <= idle_nxt;
            if (fall) high_len_q <= new_len;
            ref_len  <= ref_nxt;
            state_q  <= state_nxt;
            locked_q <= (state_nxt == LOCKED);
            gate_q   <= gate_nxt;
            cstart_q <= rise;
            err_q    <= err_q | (locked_q & short_len);
        end
    end

    assign bus.phi2_out    = phi0_s;
    assign bus.gate_out    = gate_q;
    assign bus.cycle_start = cstart_q;
    assign bus.high_len    = high_len_q;
    assign bus.locked      = locked_q;
    assign bus.timing_err  = err_q;
    assign bus.state       = state_q;
endmodule

// File: tb/tb_phi_gate_gen.sv
// Directed bench for phi_gate_gen: lock acquisition, jitter, short phase, reset, timeout, AEC.
module tb_phi_gate_gen;
    import phi_gate_gen_pkg::*;

    localparam int CW = 8;

    typedef struct packed {
        int hi;       // phi0 high clocks at the pin
        int g_first;  // first clock index with gate high (0 = none)
        int g_last;
        int len;      // high_len after the fall
        bit lock;
        bit err;
    } vec_t;

    // clock / reset
    logic clock = 1'b0;
    logic _reset;
    always #5 clock = ~clock;

    phi_gate_gen_if #(.CW(CW)) bus ();
    phi_gate_gen #(.CW(CW)) dut (.clock(clock), ._reset(_reset), .bus(bus));

    int checks   = 0;
    int failures = 0;
    logic [CW-1:0] exp_q[$];
    vec_t vecs [0:15];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] range_mask(input int lo, input int hi);
        logic [31:0] m = '0;
        if (lo > 0) for (int i = lo; i <= hi; i++) m[i] = 1'b1;
        return m;
    endfunction

    // one phi0 cycle: pin rises after P0, falls after P<hi>; 8 low clocks follow
    task automatic play(input vec_t v, input string tag);
        logic [31:0] g_m, c_m, p_m;
        int lo = 8;
        g_m = '0; c_m = '0; p_m = '0;
        exp_q.push_back(CW'(v.len));
        @(posedge clock); #2 bus.phi0_in = 1'b1;
        for (int i = 1; i <= v.hi + lo; i++) begin
            @(posedge clock);
            if (i == v.hi) #2 bus.phi0_in = 1'b0;
            @(negedge clock);
            g_m[i] = bus.gate_out;
            c_m[i] = bus.cycle_start;
            p_m[i] = bus.phi2_out;
        end
        check({tag, " gate"},   g_m, range_mask(v.g_first, v.g_last));
        check({tag, " cstart"}, c_m, range_mask(3, 3));
        check({tag, " phi2"},   p_m, range_mask(2, v.hi + 1));
        check({tag, " len"},    bus.high_len, exp_q.pop_front());
        check({tag, " lock"},   bus.locked, v.lock);
        check({tag, " err"},    bus.timing_err, v.err);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " phi2"},   bus.phi2_out, 0);
        check({tag, " gate"},   bus.gate_out, 0);
        check({tag, " aec"},    bus.aec_out, 0);
        check({tag, " cstart"}, bus.cycle_start, 0);
        check({tag, " len"},    bus.high_len, 0);
        check({tag, " lock"},   bus.locked, 0);
        check({tag, " err"},    bus.timing_err, 0);
        check({tag, " state"},  32'(bus.state), 32'(UNLOCKED));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        late_gate;
        logic [15:0] av;
        vecs = '{
            '{8,  0, 0,  8,  1'b0, 1'b0},  // first fall -> ACQUIRE
            '{8,  0, 0,  8,  1'b1, 1'b0},  // match -> LOCKED
            '{8,  5, 8,  8,  1'b1, 1'b0},  // gate over hcnt 2..5
            '{8,  5, 8,  8,  1'b1, 1'b0},
            '{9,  5, 8,  9,  1'b1, 1'b0},  // jitter 8/9
            '{8,  5, 9,  8,  1'b1, 1'b0},
            '{9,  5, 8,  9,  1'b1, 1'b0},
            '{11, 5, 9,  11, 1'b0, 1'b0},  // jump -> ACQUIRE
            '{11, 0, 0,  11, 1'b1, 1'b0},
            '{11, 5, 11, 11, 1'b1, 1'b0},
            '{5,  5, 7,  5,  1'b0, 1'b0},  // short phase cut by the fall
            '{5,  0, 0,  5,  1'b1, 1'b1},  // locked on 5 -> timing_err
            '{5,  0, 0,  5,  1'b1, 1'b1},
            '{8,  0, 0,  8,  1'b0, 1'b1},
            '{8,  0, 0,  8,  1'b1, 1'b1},
            '{8,  5, 8,  8,  1'b1, 1'b1}
        };

        _reset = 1'b0;
        bus.phi0_in = 1'b0;
        bus.aec_in  = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check_all_zero("reset");
        @(posedge clock); #2 _reset = 1'b1;
        repeat (4) @(posedge clock);

        for (int k = 0; k < 16; k++) play(vecs[k], $sformatf("v%0d", k));

        // reset while the gate is open
        @(posedge clock); #2 bus.phi0_in = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            @(posedge clock);
            @(negedge clock);
        end
        check("pre_rst gate", bus.gate_out, 1);
        check("pre_rst err", bus.timing_err, 1);
        #1 _reset = 1'b0;
        #1 check_all_zero("mid_rst");
        bus.phi0_in = 1'b0;
        repeat (3) @(posedge clock);
        #2 _reset = 1'b1;
        @(negedge clock);
        check("post_rst state", 32'(bus.state), 32'(UNLOCKED));

        play(vecs[0], "relock0");
        play(vecs[1], "relock1");
        play(vecs[2], "relock2");

        // hold phi0 high: the rise is the last edge, lock must drop near 200 clocks later
        late_gate = 1'b0;
        @(posedge clock); #2 bus.phi0_in = 1'b1;
        for (int i = 1; i <= 250; i++) begin
            @(posedge clock);
            @(negedge clock);
            if (i == 198) check("tmo still_locked", bus.locked, 1);
            if (i == 206) check("tmo dropped", bus.locked, 0);
            if (i == 206) check("tmo state", 32'(bus.state), 32'(UNLOCKED));
            if (i >= 206) late_gate = late_gate | bus.gate_out;
        end
        check("tmo gate", late_gate, 0);
        #2 bus.phi0_in = 1'b0;
        repeat (6) @(posedge clock);

        // AEC: value driven in clock k appears on aec_out in clock k+2
        av = 16'b0110_1110_0010_1101;
        for (int k = 0; k < 18; k++) begin
            @(posedge clock);
            #2 bus.aec_in = (k < 16) ? av[k] : 1'b0;
            @(negedge clock);
            if (k >= 2) check($sformatf("aec k%0d", k), bus.aec_out, av[k-2]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
